// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared encodings for the unified memory arbiter.
//   arb_state_e : arbiter sequencing states (IDLE/ISSUE/WAIT/DONE)
//   gnt_e       : owner of the access currently in flight
//   LAT_CNT_W   : latency counter width, covers MEM_LAT up to MAX_MEM_LAT
// ----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_e;

  localparam int unsigned MAX_MEM_LAT = 15;
  localparam int unsigned LAT_CNT_W   = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// ----------------------------------------------------------------------------
// mem_lat_counter
// Down-counter timing the fixed memory read latency of one access.
//   clk, reset : clock, synchronous active-high reset (clears count)
//   load       : load load_val (takes priority over dec)
//   load_val   : value loaded, MEM_LAT-1 for a fresh access
//   dec        : decrement by one, saturating at zero
//   zero_c     : combinational flag, count is zero
// ----------------------------------------------------------------------------
module mem_lat_counter
  import pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [LAT_CNT_W-1:0] load_val,
  input  logic                 dec,
  output logic                 zero_c
);

  logic [LAT_CNT_W-1:0] cnt_d;
  logic [LAT_CNT_W-1:0] cnt_q;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - LAT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// ----------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one single-port fixed-latency memory between the fetch port (F) and
// the data port (M). One access at a time: IDLE -> ISSUE -> WAIT -> DONE.
// Data has priority, except that after MAX_DATA_RUN consecutive data grants
// with a fetch waiting, the fetch is granted.
//   clk, reset            : clock, synchronous active-high reset
//   if_req/if_addr        : fetch request, held until if_ready
//   if_rdata/if_ready     : fetch data, one-cycle completion pulse
//   d_req/d_we/d_addr/
//   d_wdata               : data request (load or store), held until d_ready
//   d_rdata/d_ready       : load data, one-cycle completion pulse
//   stall_if/stall_d      : request pending and not completing this cycle
//   mem_en/mem_we/
//   mem_addr/mem_wdata    : memory strobe (one cycle per access) and payload
//   mem_rdata             : memory read data, valid MEM_LAT cycles after mem_en
// ----------------------------------------------------------------------------
module unified_mem_arbiter
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned MAX_DATA_RUN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              stall_if,
  output logic              stall_d,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned RUN_W = (MAX_DATA_RUN < 1) ? 1 : $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0]     RUN_MAX  = RUN_W'(MAX_DATA_RUN);
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT - 1);

  arb_state_e        state_d,     state_q;
  gnt_e              gnt_d,       gnt_q;
  logic              we_d,        we_q;
  logic [RUN_W-1:0]  run_cnt_d,   run_cnt_q;
  logic              mem_en_d,    mem_en_q;
  logic              mem_we_d,    mem_we_q;
  logic [ADDR_W-1:0] mem_addr_d,  mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
  logic              if_ready_d,  if_ready_q;
  logic              d_ready_d,   d_ready_q;
  logic [DATA_W-1:0] if_rdata_d,  if_rdata_q;
  logic [DATA_W-1:0] d_rdata_d,   d_rdata_q;

  logic              any_req_c;
  logic              fetch_wins_c;
  logic              lat_load_c;
  logic              lat_dec_c;
  logic              lat_zero_c;

  // Data wins unless the waiting fetch has already been passed over
  // MAX_DATA_RUN times in a row.
  assign any_req_c    = if_req | d_req;
  assign fetch_wins_c = if_req & (~d_req | (run_cnt_q == RUN_MAX));

  mem_lat_counter u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (lat_load_c),
    .load_val (LAT_LOAD),
    .dec      (lat_dec_c),
    .zero_c   (lat_zero_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req_c) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (lat_zero_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic. mem_en and ready are set on the transition into
  // ISSUE and DONE so that the registered outputs line up with those states.
  always_comb begin
    gnt_d       = gnt_q;
    we_d        = we_q;
    run_cnt_d   = run_cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    lat_load_c  = 1'b0;
    lat_dec_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!if_req) begin
          run_cnt_d = '0;
        end
        if (any_req_c) begin
          mem_en_d = 1'b1;
          if (fetch_wins_c) begin
            gnt_d       = GNT_FETCH;
            we_d        = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            run_cnt_d   = '0;
          end else begin
            gnt_d       = GNT_DATA;
            we_d        = d_we;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            // Only count data grants that actually made a fetch wait.
            if (if_req) begin
              run_cnt_d = run_cnt_q + RUN_W'(1);
            end
          end
        end
      end
      ISSUE: begin
        lat_load_c = 1'b1;
      end
      WAIT: begin
        if (lat_zero_c) begin
          if (gnt_q == GNT_FETCH) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_ready_d = 1'b1;
            // Stores leave the previous load data visible.
            if (!we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else begin
          lat_dec_c = 1'b1;
        end
      end
      DONE: begin
      end
      default: begin
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q       <= GNT_FETCH;
      we_q        <= 1'b0;
      run_cnt_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      run_cnt_q   <= run_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  // Stalls follow the live request so a dropped request stops stalling at once.
  assign stall_if = if_req & ~if_ready_q;
  assign stall_d  = d_req & ~d_ready_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_unified_mem_arbiter
// Directed scenarios plus a randomized phase checked against a
// transaction-level model of the arbiter (grant rule, fixed access timing,
// memory contents). A second instance is built with MEM_LAT=1.
// ----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

  localparam int unsigned TB_LAT = 2;
  localparam int unsigned TB_MAX = 2;

  logic        clk;
  logic        reset;

  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, d_ready, stall_if, stall_d, mem_en, mem_we;

  logic        if_req_1, d_req_1, d_we_1;
  logic [31:0] if_addr_1, d_addr_1, d_wdata_1;
  logic [31:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic        if_ready_1, d_ready_1, stall_if_1, stall_d_1, mem_en_1, mem_we_1;

  int n_cmp = 0;
  int n_mis = 0;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(TB_LAT), .MAX_DATA_RUN(TB_MAX)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .stall_if(stall_if), .stall_d(stall_d),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_DATA_RUN(TB_MAX)) u_dut_1 (
    .clk(clk), .reset(reset),
    .if_req(if_req_1), .if_addr(if_addr_1), .if_rdata(if_rdata_1), .if_ready(if_ready_1),
    .d_req(d_req_1), .d_we(d_we_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1),
    .d_rdata(d_rdata_1), .d_ready(d_ready_1),
    .stall_if(stall_if_1), .stall_d(stall_d_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return {16'hA5A5, 8'(i), 8'h3C};
  endfunction

  // Memory for the MEM_LAT=2 instance: 64 words, reinitialized on reset.
  // Outside the valid read slot the data bus carries a poison value.
  logic [31:0] tb_mem  [64];
  logic [31:0] rd_pipe [TB_LAT];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= init_word(i);
      for (int i = 0; i < int'(TB_LAT); i++) rd_pipe[i] <= 32'hBADBAD00;
    end else begin
      if (mem_en && mem_we) tb_mem[mem_addr[7:2]] <= mem_wdata;
      rd_pipe[0] <= (mem_en && !mem_we) ? tb_mem[mem_addr[7:2]] : 32'hBADBAD00;
      for (int i = 1; i < int'(TB_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign mem_rdata = rd_pipe[TB_LAT-1];

  // Memory for the MEM_LAT=1 instance: read data is a function of address.
  logic [31:0] rd_1;
  always @(posedge clk) begin
    rd_1 <= mem_en_1 ? (mem_addr_1 ^ 32'h5A5A0000) : 32'hBAD1BAD1;
  end
  assign mem_rdata_1 = rd_1;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    if_req_1 = 0; if_addr_1 = '0; d_req_1 = 0; d_we_1 = 0; d_addr_1 = '0; d_wdata_1 = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference model state for the randomized phase.
  logic [31:0] ref_mem [64];
  logic [31:0] exp_if, exp_d, m_addr, m_wdata, m_rd;
  logic        m_data, m_we, exp_ifr, exp_dr, pif, pd, flushed, fw;
  int          run, next_sample, iss_c, rdy_c;
  logic [31:0] t3_addr [7];

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    #1;
    chk1 ("rst_mem_en",    mem_en,    1'b0);
    chk1 ("rst_mem_we",    mem_we,    1'b0);
    chk32("rst_mem_addr",  mem_addr,  32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk1 ("rst_if_ready",  if_ready,  1'b0);
    chk1 ("rst_d_ready",   d_ready,   1'b0);
    chk32("rst_if_rdata",  if_rdata,  32'h0);
    chk32("rst_d_rdata",   d_rdata,   32'h0);
    chk1 ("rst_stall_if",  stall_if,  1'b0);

    // ---------------- 1: fetch-only load ----------------
    if_req = 1; if_addr = 32'h10;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      if (k == 5) if_req = 0;
      #1;
      chk1("t1_mem_en", mem_en, k == 1);
      if (k == 1) chk32("t1_mem_addr", mem_addr, 32'h10);
      chk1("t1_if_ready", if_ready, k == 4);
      chk1("t1_d_ready", d_ready, 1'b0);
      if (k >= 4) chk32("t1_if_rdata", if_rdata, 32'hDEADBEEF);
      chk1("t1_stall_if", stall_if, k < 4);
    end

    // ---------------- 2: simultaneous requests ----------------
    tick();
    if_req = 1; if_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h100;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) tick();
      if (k == 5) d_req = 0;
      if (k == 10) if_req = 0;
      #1;
      chk1("t2_mem_en", mem_en, (k == 1) || (k == 6));
      if (k == 1) chk32("t2_addr_data", mem_addr, 32'h100);
      if (k == 6) chk32("t2_addr_fetch", mem_addr, 32'h20);
      chk1("t2_d_ready", d_ready, k == 4);
      chk1("t2_if_ready", if_ready, k == 9);
      chk1("t2_stall_if", stall_if, k < 9);
      chk1("t2_stall_d", stall_d, k < 4);
      if (k == 4) chk32("t2_d_rdata", d_rdata, init_word(0));
      if (k == 9) chk32("t2_if_rdata", if_rdata, init_word(8));
    end

    // ---------------- 3: anti-starvation ----------------
    t3_addr[0] = 32'h80; t3_addr[1] = 32'h80; t3_addr[2] = 32'h30; t3_addr[3] = 32'h80;
    t3_addr[4] = 32'h80; t3_addr[5] = 32'h30; t3_addr[6] = 32'h80;
    tick();
    if_req = 1; if_addr = 32'h30; d_req = 1; d_we = 0; d_addr = 32'h80;
    for (int k = 0; k <= 35; k++) begin
      if (k > 0) tick();
      if (k == 35) begin if_req = 0; d_req = 0; end
      #1;
      chk1("t3_mem_en", mem_en, (k % 5 == 1) && (k <= 31));
      if ((k % 5 == 1) && (k <= 31)) chk32("t3_grant_addr", mem_addr, t3_addr[k / 5]);
      chk1("t3_if_ready", if_ready, (k == 14) || (k == 29));
      chk1("t3_d_ready", d_ready, (k % 5 == 4) && (k != 14) && (k != 29));
    end
    chk32("t3_d_rdata", d_rdata, init_word(32));
    chk32("t3_if_rdata", if_rdata, init_word(12));

    // ---------------- 4: store, then load back ----------------
    tick();
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hCAFE0001;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      if (k == 5) d_req = 0;
      #1;
      chk1("t4_mem_en", mem_en, k == 1);
      chk1("t4_mem_we", mem_we, k == 1);
      if (k == 1 || k == 2) begin
        chk32("t4_mem_addr", mem_addr, 32'h40);
        chk32("t4_mem_wdata", mem_wdata, 32'hCAFE0001);
      end
      chk1("t4_d_ready", d_ready, k == 4);
      chk32("t4_d_rdata_hold", d_rdata, init_word(32));
    end
    tick();
    d_req = 1; d_we = 0; d_addr = 32'h40;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      if (k == 5) d_req = 0;
      #1;
      chk1("t4_ld_mem_we", mem_we, 1'b0);
      chk1("t4_ld_d_ready", d_ready, k == 4);
      if (k >= 4) chk32("t4_ld_d_rdata", d_rdata, 32'hCAFE0001);
    end

    // ---------------- 6: MEM_LAT=1 instance ----------------
    tick();
    if_req_1 = 1; if_addr_1 = 32'h44;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) tick();
      if (k == 4) if_req_1 = 0;
      #1;
      chk1("t6_f_mem_en", mem_en_1, k == 1);
      chk1("t6_f_if_ready", if_ready_1, k == 3);
      if (k >= 3) chk32("t6_f_if_rdata", if_rdata_1, 32'h5A5A0044);
    end
    tick();
    d_req_1 = 1; d_we_1 = 0; d_addr_1 = 32'h48;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      if (k == 8) d_req_1 = 0;
      #1;
      chk1("t6_d_mem_en", mem_en_1, (k == 1) || (k == 5));
      chk1("t6_d_ready", d_ready_1, (k == 3) || (k == 7));
      chk1("t6_stall_d", stall_d_1, (k < 8) && (k != 3) && (k != 7));
      if (k == 7) chk32("t6_d_rdata", d_rdata_1, 32'h5A5A0048);
    end

    // ---------------- 5: reset during WAIT ----------------
    tick();
    if_req = 1; if_addr = 32'h14;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) tick();
      if (k == 2) reset = 1;
      if (k == 3) begin reset = 0; if_req = 0; end
      #1;
      if (k == 3) begin
        chk1 ("t5_mem_en",    mem_en,    1'b0);
        chk1 ("t5_mem_we",    mem_we,    1'b0);
        chk32("t5_mem_addr",  mem_addr,  32'h0);
        chk32("t5_mem_wdata", mem_wdata, 32'h0);
        chk32("t5_if_rdata",  if_rdata,  32'h0);
        chk32("t5_d_rdata",   d_rdata,   32'h0);
        chk1 ("t5_d_ready",   d_ready,   1'b0);
      end
      if (k >= 3) chk1("t5_mem_en_quiet", mem_en, 1'b0);
      chk1("t5_no_if_ready", if_ready, 1'b0);
    end
    if_req = 1; if_addr = 32'h10;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      if (k == 5) if_req = 0;
      #1;
      chk1("t5_new_mem_en", mem_en, k == 1);
      chk1("t5_new_if_ready", if_ready, k == 4);
      if (k == 4) chk32("t5_new_if_rdata", if_rdata, 32'hDEADBEEF);
    end

    // ---------------- randomized phase vs. model ----------------
    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    exp_if = '0; exp_d = '0; run = 0; next_sample = 1; iss_c = -100; rdy_c = -100;
    m_data = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_rd = '0;
    pif = 0; pd = 0; flushed = 0;
    for (int c = 1; c <= 600; c++) begin
      tick();
      // registered outputs of cycle c
      exp_ifr = (c == rdy_c) && !m_data;
      exp_dr  = (c == rdy_c) && m_data;
      if (c == rdy_c) begin
        if (!m_data) exp_if = m_rd;
        else if (!m_we) exp_d = m_rd;
      end
      chk1("r_mem_en", mem_en, c == iss_c);
      chk1("r_mem_we", mem_we, (c == iss_c) && m_we);
      if (c == iss_c) begin
        chk32("r_mem_addr", mem_addr, m_addr);
        if (m_we) chk32("r_mem_wdata", mem_wdata, m_wdata);
      end
      chk1 ("r_if_ready", if_ready, exp_ifr);
      chk1 ("r_d_ready",  d_ready,  exp_dr);
      chk32("r_if_rdata", if_rdata, exp_if);
      chk32("r_d_rdata",  d_rdata,  exp_d);

      // requesters react to the previous cycle's completion
      if (pif) begin if_req = 0; flushed = 0; end
      if (pd) d_req = 0;
      if (if_req && !m_data && (c >= iss_c) && (c < rdy_c) && ($urandom_range(0, 9) == 0)) begin
        if_req = 0;
        flushed = 1;
      end
      if (!if_req && !flushed && ($urandom_range(0, 2) == 0)) begin
        if_req = 1;
        if_addr = {24'h0, 6'($urandom), 2'b00};
      end
      if (!d_req && ($urandom_range(0, 2) == 0)) begin
        d_req = 1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = {24'h0, 6'($urandom), 2'b00};
        d_wdata = $urandom;
      end
      #1;
      chk1("r_stall_if", stall_if, if_req && !exp_ifr);
      chk1("r_stall_d",  stall_d,  d_req && !exp_dr);
      pif = exp_ifr;
      pd  = exp_dr;

      // arbiter decision when it is free to sample
      if (c == next_sample) begin
        if (!if_req) run = 0;
        if (if_req || d_req) begin
          fw = if_req && (!d_req || (run == int'(TB_MAX)));
          if (fw) begin
            m_data = 0; m_we = 0; m_addr = if_addr; m_wdata = '0;
            run = 0;
          end else begin
            m_data = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
            if (if_req) run = run + 1;
          end
          m_rd = ref_mem[m_addr[7:2]];
          if (m_we) ref_mem[m_addr[7:2]] = m_wdata;
          iss_c = c + 1;
          rdy_c = c + int'(TB_LAT) + 2;
          next_sample = c + int'(TB_LAT) + 3;
        end else begin
          next_sample = c + 1;
        end
      end
    end
    if_req = 0; d_req = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
